// File: rtl/snake_engine_if.sv
// Control, readout and status bundle between the snake engine and the
// direction decoder, random source and renderer.
interface snake_engine_if #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int LEN_W   = 8,
    parameter int SCORE_W = 8
);
    logic               start;
    logic               tick;
    logic [1:0]         dir;
    logic               dir_valid;
    logic [X_W-1:0]     rnd_x;
    logic [Y_W-1:0]     rnd_y;
    logic [LEN_W-1:0]   rd_idx;
    logic [X_W-1:0]     rd_x;
    logic [Y_W-1:0]     rd_y;
    logic               rd_valid;
    logic [X_W-1:0]     head_x;
    logic [Y_W-1:0]     head_y;
    logic [X_W-1:0]     apple_x;
    logic [Y_W-1:0]     apple_y;
    logic [LEN_W-1:0]   length;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               eaten;
    logic               game_over;

    modport master (
        output start, tick, dir, dir_valid, rnd_x, rnd_y, rd_idx,
        input  rd_x, rd_y, rd_valid, head_x, head_y, apple_x, apple_y,
               length, score, busy, eaten, game_over
    );
    modport slave (
        input  start, tick, dir, dir_valid, rnd_x, rnd_y, rd_idx,
        output rd_x, rd_y, rd_valid, head_x, head_y, apple_x, apple_y,
               length, score, busy, eaten, game_over
    );
endinterface

// File: rtl/snake_engine.sv
// Grid snake core: circular body buffer, per-tick move with serial self-collision
// scan, growth, apple placement, score and a registered body readout port.
module snake_engine #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int X_W      = 6,
    parameter int Y_W      = 6,
    parameter int MAX_LEN  = 128,
    parameter int LEN_W    = 8,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 0,
    parameter int APPLE0_X = 16,
    parameter int APPLE0_Y = 12,
    parameter int SCORE_W  = 8
) (
    input  logic          clk,
    input  logic          rst_game,
    snake_engine_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam logic [2:0] S_IDLE = 3'd0, S_INIT = 3'd1, S_RUN = 3'd2, S_CALC = 3'd3,
                           S_SCAN = 3'd4, S_COMMIT = 3'd5, S_OVER = 3'd6;
    localparam logic [X_W-1:0]   CX     = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0]   CY     = Y_W'(GRID_H / 2);
    localparam logic [X_W-1:0]   XMAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   YMAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0]   AX0    = X_W'(APPLE0_X);
    localparam logic [Y_W-1:0]   AY0    = Y_W'(APPLE0_Y);
    localparam logic [LEN_W-1:0] L_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] L_INIT = LEN_W'(INIT_LEN);

    logic [2:0]           r_state;
    logic [X_W+Y_W-1:0]   r_buf [MAX_LEN];
    logic [PTR_W-1:0]     r_head_ptr;
    logic [X_W-1:0]       r_head_x, r_apple_x, r_nh_x, r_rd_x;
    logic [Y_W-1:0]       r_head_y, r_apple_y, r_nh_y, r_rd_y;
    logic [LEN_W-1:0]     r_len, r_cnt, r_scan_n;
    logic [SCORE_W-1:0]   r_score;
    logic [1:0]           r_cur_dir, r_pend_dir;
    logic                 r_grow, r_hit, r_eaten, r_rd_valid;

    logic [X_W-1:0]       w_nh_x, w_apple_x;
    logic [Y_W-1:0]       w_nh_y, w_apple_y;
    logic                 w_oob, w_dir_ld, w_nh_apple;
    logic [1:0]           w_pend_nxt;
    logic [PTR_W-1:0]     w_ptr_dec, w_rd_ptr, w_scan_ptr;
    logic [X_W+Y_W-1:0]   w_rd_xy, w_scan_xy;

    assign w_dir_ld   = bus.dir_valid && (r_state != S_IDLE) && (r_state != S_INIT) &&
                        (bus.dir != (r_cur_dir ^ 2'b10));
    assign w_pend_nxt = w_dir_ld ? bus.dir : r_pend_dir;
    assign w_ptr_dec  = r_head_ptr - 1'b1;
    assign w_rd_ptr   = r_head_ptr + PTR_W'(bus.rd_idx);
    assign w_scan_ptr = r_head_ptr + PTR_W'(r_cnt);
    assign w_rd_xy    = r_buf[w_rd_ptr];
    assign w_scan_xy  = r_buf[w_scan_ptr];
    assign w_nh_apple = (w_nh_x == r_apple_x) && (w_nh_y == r_apple_y);

    // Random coordinates are folded back into the grid with one subtraction.
    assign w_apple_x = ({1'b0, bus.rnd_x} >= (X_W+1)'(GRID_W)) ? bus.rnd_x - X_W'(GRID_W) : bus.rnd_x;
    assign w_apple_y = ({1'b0, bus.rnd_y} >= (Y_W+1)'(GRID_H)) ? bus.rnd_y - Y_W'(GRID_H) : bus.rnd_y;

    // Next head; edge crossings either flag out-of-bounds or wrap around.
    always_comb begin
        w_nh_x = r_head_x;
        w_nh_y = r_head_y;
        w_oob  = 1'b0;
        case (r_cur_dir)
            2'b00: if (r_head_x == XMAX) begin w_oob = (WRAP == 0); w_nh_x = '0; end
                   else w_nh_x = r_head_x + 1'b1;
            2'b01: if (r_head_y == YMAX) begin w_oob = (WRAP == 0); w_nh_y = '0; end
                   else w_nh_y = r_head_y + 1'b1;
            2'b10: if (r_head_x == '0) begin w_oob = (WRAP == 0); w_nh_x = XMAX; end
                   else w_nh_x = r_head_x - 1'b1;
            default: if (r_head_y == '0) begin w_oob = (WRAP == 0); w_nh_y = YMAX; end
                   else w_nh_y = r_head_y - 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_INIT)
            r_buf[PTR_W'(r_cnt)] <= {CX - X_W'(r_cnt), CY};
        else if (r_state == S_COMMIT)
            r_buf[w_ptr_dec] <= {r_nh_x, r_nh_y};
    end

    always_ff @(posedge clk or negedge rst_game) begin
        if (!rst_game) begin
            r_state    <= S_IDLE;
            r_head_ptr <= '0;
            r_head_x   <= CX;
            r_head_y   <= CY;
            r_apple_x  <= AX0;
            r_apple_y  <= AY0;
            r_nh_x     <= '0;
            r_nh_y     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_scan_n   <= '0;
            r_score    <= '0;
            r_cur_dir  <= 2'b00;
            r_pend_dir <= 2'b00;
            r_grow     <= 1'b0;
            r_hit      <= 1'b0;
            r_eaten    <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_eaten    <= 1'b0;
            r_rd_x     <= w_rd_xy[X_W+Y_W-1:Y_W];
            r_rd_y     <= w_rd_xy[Y_W-1:0];
            r_rd_valid <= bus.rd_idx < r_len;
            if (w_dir_ld) r_pend_dir <= bus.dir;
            if (!bus.start) begin
                r_state   <= S_IDLE;
                r_len     <= '0;
                r_score   <= '0;
                r_apple_x <= AX0;
                r_apple_y <= AY0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_INIT;
                        r_cnt      <= '0;
                        r_head_ptr <= '0;
                        r_head_x   <= CX;
                        r_head_y   <= CY;
                    end
                    S_INIT: begin
                        if (r_cnt == L_INIT - 1'b1) begin
                            r_len      <= L_INIT;
                            r_cur_dir  <= 2'b00;
                            r_pend_dir <= 2'b00;
                            r_state    <= S_RUN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_RUN: if (bus.tick) begin
                        r_cur_dir <= w_pend_nxt;
                        r_state   <= S_CALC;
                    end
                    S_CALC: begin
                        r_nh_x   <= w_nh_x;
                        r_nh_y   <= w_nh_y;
                        r_hit    <= w_nh_apple;
                        r_grow   <= w_nh_apple && (r_len < L_MAX);
                        // The tail slot is vacated this move unless the snake grows.
                        r_scan_n <= (w_nh_apple && (r_len < L_MAX)) ? r_len : r_len - 1'b1;
                        r_cnt    <= '0;
                        r_state  <= w_oob ? S_OVER : S_SCAN;
                    end
                    S_SCAN: begin
                        if (w_scan_xy == {r_nh_x, r_nh_y})   r_state <= S_OVER;
                        else if (r_cnt == r_scan_n - 1'b1)   r_state <= S_COMMIT;
                        else                                 r_cnt   <= r_cnt + 1'b1;
                    end
                    S_COMMIT: begin
                        r_head_ptr <= w_ptr_dec;
                        r_head_x   <= r_nh_x;
                        r_head_y   <= r_nh_y;
                        if (r_grow) r_len <= r_len + 1'b1;
                        if (r_hit) begin
                            if (r_score != '1) r_score <= r_score + 1'b1;
                            r_eaten   <= 1'b1;
                            r_apple_x <= w_apple_x;
                            r_apple_y <= w_apple_y;
                        end
                        r_state <= S_RUN;
                    end
                    S_OVER: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.rd_x      = r_rd_x;
    assign bus.rd_y      = r_rd_y;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.head_x    = r_head_x;
    assign bus.head_y    = r_head_y;
    assign bus.apple_x   = r_apple_x;
    assign bus.apple_y   = r_apple_y;
    assign bus.length    = r_len;
    assign bus.score     = r_score;
    assign bus.busy      = (r_state == S_INIT) || (r_state == S_CALC) ||
                           (r_state == S_SCAN) || (r_state == S_COMMIT);
    assign bus.eaten     = r_eaten;
    assign bus.game_over = (r_state == S_OVER);
endmodule

// File: tb/tb_snake_engine.sv
// Drives a walled and a wrapping engine with the same inputs and checks both
// against a list-based model of the game rules (index 0 = head).
module tb_snake_engine;
    localparam int GW = 64, GH = 48, XW = 6, YW = 6, ML = 128, LW = 8, SW = 8, IL = 3;

    logic clk = 1'b0;
    logic rst_game;
    always #5 clk = ~clk;

    snake_engine_if #(.X_W(XW), .Y_W(YW), .LEN_W(LW), .SCORE_W(SW)) if0 ();
    snake_engine_if #(.X_W(XW), .Y_W(YW), .LEN_W(LW), .SCORE_W(SW)) if1 ();

    assign if1.start     = if0.start;
    assign if1.tick      = if0.tick;
    assign if1.dir       = if0.dir;
    assign if1.dir_valid = if0.dir_valid;
    assign if1.rnd_x     = if0.rnd_x;
    assign if1.rnd_y     = if0.rnd_y;
    assign if1.rd_idx    = if0.rd_idx;

    snake_engine #(.WRAP(0)) dut0 (.clk(clk), .rst_game(rst_game), .bus(if0.slave));
    snake_engine #(.WRAP(1), .APPLE0_X(33), .APPLE0_Y(24)) dut1 (.clk(clk), .rst_game(rst_game), .bus(if1.slave));

    typedef struct packed {
        logic [31:0] hx, hy, ax, ay, len, sc, busy, go, eat, rx, ry, rv;
    } obs_t;

    int nvec = 0, nerr = 0;
    int wrapk[2] = '{0, 1};
    int a0x[2] = '{16, 33};
    int a0y[2] = '{12, 24};
    int bx[2][ML+1], by[2][ML+1];
    int mlen[2], msc[2], mapx[2], mapy[2], mcur[2], mpend[2], ecyc[2];
    bit mover[2], eate[2];

    function automatic obs_t grab(input int k);
        obs_t o;
        if (k == 0) begin
            o.hx = 32'(if0.head_x);  o.hy = 32'(if0.head_y);
            o.ax = 32'(if0.apple_x); o.ay = 32'(if0.apple_y);
            o.len = 32'(if0.length); o.sc = 32'(if0.score);
            o.busy = 32'(if0.busy);  o.go = 32'(if0.game_over); o.eat = 32'(if0.eaten);
            o.rx = 32'(if0.rd_x);    o.ry = 32'(if0.rd_y);      o.rv = 32'(if0.rd_valid);
        end else begin
            o.hx = 32'(if1.head_x);  o.hy = 32'(if1.head_y);
            o.ax = 32'(if1.apple_x); o.ay = 32'(if1.apple_y);
            o.len = 32'(if1.length); o.sc = 32'(if1.score);
            o.busy = 32'(if1.busy);  o.go = 32'(if1.game_over); o.eat = 32'(if1.eaten);
            o.rx = 32'(if1.rd_x);    o.ry = 32'(if1.rd_y);      o.rv = 32'(if1.rd_valid);
        end
        return o;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s[%0d]: got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    function automatic void model_start(input int k);
        mlen[k] = IL; msc[k] = 0; mapx[k] = a0x[k]; mapy[k] = a0y[k];
        mcur[k] = 0; mpend[k] = 0; mover[k] = 0;
        for (int i = 0; i < IL; i++) begin bx[k][i] = GW/2 - i; by[k][i] = GH/2; end
    endfunction

    // One move by the game rules; records the expected cycles until busy drops.
    function automatic void model_tick(input int k, input int rx, input int ry);
        int nx, ny, n;
        bit grow;
        eate[k] = 0;
        if (mover[k]) begin ecyc[k] = 1; return; end
        mcur[k] = mpend[k];
        nx = bx[k][0] + ((mcur[k] == 0) ? 1 : (mcur[k] == 2) ? -1 : 0);
        ny = by[k][0] + ((mcur[k] == 1) ? 1 : (mcur[k] == 3) ? -1 : 0);
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            if (wrapk[k] == 0) begin mover[k] = 1; ecyc[k] = 1; return; end
            nx = (nx + GW) % GW;
            ny = (ny + GH) % GH;
        end
        eate[k] = (nx == mapx[k]) && (ny == mapy[k]);
        grow = eate[k] && (mlen[k] < ML);
        n = grow ? mlen[k] : mlen[k] - 1;
        for (int j = 0; j < n; j++)
            if (bx[k][j] == nx && by[k][j] == ny) begin
                mover[k] = 1; eate[k] = 0; ecyc[k] = 2 + j; return;
            end
        for (int j = (mlen[k] < ML) ? mlen[k] : ML - 1; j > 0; j--) begin
            bx[k][j] = bx[k][j-1]; by[k][j] = by[k][j-1];
        end
        bx[k][0] = nx; by[k][0] = ny;
        if (grow) mlen[k]++;
        if (eate[k]) begin
            if (msc[k] < (1 << SW) - 1) msc[k]++;
            mapx[k] = (rx % (1 << XW) >= GW) ? rx % (1 << XW) - GW : rx % (1 << XW);
            mapy[k] = (ry % (1 << YW) >= GH) ? ry % (1 << YW) - GH : ry % (1 << YW);
        end
        ecyc[k] = n + 2;
    endfunction

    task automatic check_model(input string tag, input int k);
        obs_t o;
        o = grab(k);
        check({tag, ".hx"}, k, o.hx, bx[k][0]);
        check({tag, ".hy"}, k, o.hy, by[k][0]);
        check({tag, ".ax"}, k, o.ax, mapx[k]);
        check({tag, ".ay"}, k, o.ay, mapy[k]);
        check({tag, ".len"}, k, o.len, mlen[k]);
        check({tag, ".score"}, k, o.sc, msc[k]);
        check({tag, ".over"}, k, o.go, 32'(mover[k]));
        check({tag, ".busy"}, k, o.busy, 0);
    endtask

    task automatic check_reset(input string tag);
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            o = grab(k);
            check({tag, ".hx"}, k, o.hx, GW/2);
            check({tag, ".hy"}, k, o.hy, GH/2);
            check({tag, ".ax"}, k, o.ax, a0x[k]);
            check({tag, ".ay"}, k, o.ay, a0y[k]);
            check({tag, ".len"}, k, o.len, 0);
            check({tag, ".score"}, k, o.sc, 0);
            check({tag, ".busy"}, k, o.busy, 0);
            check({tag, ".over"}, k, o.go, 0);
            check({tag, ".eaten"}, k, o.eat, 0);
            check({tag, ".rdx"}, k, o.rx, 0);
            check({tag, ".rdy"}, k, o.ry, 0);
            check({tag, ".rdv"}, k, o.rv, 0);
        end
    endtask

    task automatic start_game();
        @(negedge clk); if0.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) check("init.busy", k, grab(k).busy, 1);
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 2; k++) check("init.len_early", k, grab(k).len, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin model_start(k); check_model("init", k); end
    endtask

    task automatic restart();
        obs_t o;
        @(negedge clk); if0.start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = grab(k);
            check("idle.len", k, o.len, 0);
            check("idle.score", k, o.sc, 0);
            check("idle.ax", k, o.ax, a0x[k]);
            check("idle.ay", k, o.ay, a0y[k]);
            check("idle.over", k, o.go, 0);
        end
        start_game();
    endtask

    task automatic set_dir(input int d);
        @(negedge clk); if0.dir = 2'(d); if0.dir_valid = 1'b1;
        @(negedge clk); if0.dir_valid = 1'b0;
        for (int k = 0; k < 2; k++)
            if (d != (mcur[k] ^ 2)) mpend[k] = d;
    endtask

    task automatic do_tick(input int rx, input int ry);
        int c, dat[2], eseen[2];
        bit done[2];
        @(negedge clk);
        if0.rnd_x = XW'(rx); if0.rnd_y = YW'(ry);
        for (int k = 0; k < 2; k++) begin model_tick(k, rx, ry); done[k] = 0; dat[k] = 0; eseen[k] = 0; end
        if0.tick = 1'b1;
        @(negedge clk); if0.tick = 1'b0;
        c = 0;
        while (!(done[0] && done[1]) && c < 400) begin
            @(posedge clk); #1; c++;
            for (int k = 0; k < 2; k++) begin
                if (!done[k] && grab(k).busy === 32'd0) begin done[k] = 1; dat[k] = c; end
                if (grab(k).eat === 32'd1) eseen[k]++;
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if (grab(k).eat === 32'd1) eseen[k]++;
            check("tick.latency", k, dat[k], ecyc[k]);
            check("tick.eaten", k, eseen[k], eate[k] ? 1 : 0);
            check_model("tick", k);
        end
    endtask

    task automatic check_body();
        obs_t o;
        int maxl;
        maxl = (mlen[0] > mlen[1]) ? mlen[0] : mlen[1];
        for (int i = 0; i <= maxl; i++) begin
            @(negedge clk); if0.rd_idx = LW'(i);
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                o = grab(k);
                if (i < mlen[k]) begin
                    check("body.x", k, o.rx, bx[k][i]);
                    check("body.y", k, o.ry, by[k][i]);
                    check("body.valid", k, o.rv, 1);
                end else begin
                    check("body.invalid", k, o.rv, 0);
                end
            end
        end
    endtask

    initial begin
        if0.start = 1'b0; if0.tick = 1'b0; if0.dir = 2'b00; if0.dir_valid = 1'b0;
        if0.rnd_x = '0; if0.rnd_y = '0; if0.rd_idx = '0;
        rst_game = 1'b1;
        #1 rst_game = 1'b0;
        #2 check_reset("reset");
        @(negedge clk); rst_game = 1'b1;
        start_game();
        check_body();

        // First move: walled snake steps right, wrapping snake eats its apple.
        do_tick(70, 10);
        set_dir(2); do_tick(3, 3);
        set_dir(1); do_tick(3, 3);
        check_body();

        // Run into the right wall (walled) / across it (wrapping).
        restart();
        for (int i = 0; i < 32; i++) do_tick(5, 5);
        check("wall.over", 0, grab(0).go, 1);
        check("wall.hx", 0, grab(0).hx, GW - 1);
        check("wrap.hx", 1, grab(1).hx, 0);

        // Grow the wrapping snake to 5 and turn it into its own body.
        restart();
        do_tick(34, 24);
        do_tick(5, 5);
        set_dir(1); do_tick(5, 5);
        set_dir(2); do_tick(5, 5);
        set_dir(3); do_tick(5, 5);
        check("selfhit.over", 1, grab(1).go, 1);
        check_body();

        // Random play.
        restart();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) set_dir(int'($urandom_range(0, 3)));
            do_tick(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            if (i % 15 == 14) check_body();
            if (mover[0] && mover[1]) restart();
        end

        // Asynchronous reset while scanning.
        restart();
        @(negedge clk); if0.tick = 1'b1;
        @(negedge clk); if0.tick = 1'b0;
        @(posedge clk); #2;
        check("scan.busy", 0, grab(0).busy, 1);
        rst_game = 1'b0;
        #1 check_reset("midscan");
        @(negedge clk); rst_game = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
